// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath blocks:
// collector FSM encoding, saturating-add widths and index sizing.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // One guard bit is enough to detect overflow of a two-operand signed add.
  localparam int SatGuardBits = 1;

  // Counter width for n positions; never below one bit so degenerate sizes still elaborate.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Bus between the systolic array / downstream consumer and psum_collector.
interface psum_collector_if #(
  parameter int PsumWidth = 16
);
  // Handshakes: psumValid is a one-sided strobe (the collector has no stall path),
  // a psum transfers on every rising edge with psumValid=1 in COLLECT. outData
  // transfers on a rising edge where outValid && outReady; while outValid=1 and
  // outReady=0 the collector holds outData and outValid unchanged.
  logic                 start;
  logic                 psumValid;
  logic [PsumWidth-1:0] psumIn;
  logic                 outValid;
  logic [PsumWidth-1:0] outData;
  logic                 outReady;
  logic                 busy;
  logic                 done;
  logic                 protoErr;

  modport master (
    output start, psumValid, psumIn, outReady,
    input  outValid, outData, busy, done, protoErr
  );

  modport slave (
    input  start, psumValid, psumIn, outReady,
    output outValid, outData, busy, done, protoErr
  );

endinterface

// File: rtl/sat_add.sv
// Two's-complement adder that clamps to the representable range instead of wrapping.
module sat_add
  import mm_pkg::*;
#(
  parameter int PsumWidth = 16
) (
  input  logic [PsumWidth-1:0] a,
  input  logic [PsumWidth-1:0] b,
  output logic [PsumWidth-1:0] y
);

  localparam int SumW = PsumWidth + SatGuardBits;
  localparam logic [PsumWidth-1:0] MaxVal = {1'b0, {(PsumWidth-1){1'b1}}};
  localparam logic [PsumWidth-1:0] MinVal = {1'b1, {(PsumWidth-1){1'b0}}};

  logic [SumW-1:0] sum;

  always_comb begin
    sum = {a[PsumWidth-1], a} + {b[PsumWidth-1], b};
    y   = sum[PsumWidth-1:0];
    // Guard bit disagreeing with the result sign bit means the add overflowed.
    if (sum[SumW-1] != sum[SumW-2]) begin
      y = sum[SumW-1] ? MinVal : MaxVal;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Accumulates Passes partial-sum passes of Height rows into a local buffer,
// then drains the results with a valid/ready output.
module psum_collector
  import mm_pkg::*;
#(
  parameter int Height    = 4,
  parameter int PsumWidth = 16,
  parameter int Passes    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  psum_collector_if.slave        bus,
  output state_t                 dbg_state
);

  localparam int IdxW  = idx_bits(Height);
  localparam int PassW = idx_bits(Passes);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(Height - 1);
  localparam logic [PassW-1:0] LastPass = PassW'(Passes - 1);

  state_t               state;
  logic [IdxW-1:0]      wr_idx;
  logic [IdxW-1:0]      rd_idx;
  logic [PassW-1:0]     pass_cnt;
  logic [PsumWidth-1:0] psum_buf [Height];
  logic [PsumWidth-1:0] sat_y;
  logic [PsumWidth-1:0] wr_val;
  logic [IdxW-1:0]      rd_nxt;
  logic                 buf_we;
  logic                 out_valid_q;
  logic [PsumWidth-1:0] out_data_q;
  logic                 done_q;
  logic                 proto_err_q;

  sat_add #(.PsumWidth(PsumWidth)) u_sat_add (
    .a (psum_buf[wr_idx]),
    .b (bus.psumIn),
    .y (sat_y)
  );

  always_comb begin
    wr_val = (pass_cnt == '0) ? bus.psumIn : sat_y;
    buf_we = (state == ST_COLLECT) && bus.psumValid;
    rd_nxt = rd_idx + 1'b1;
  end

  // Buffer has no reset: it is always fully rewritten by pass 0 before any readback.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      psum_buf[wr_idx] <= wr_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_idx      <= '0;
      rd_idx      <= '0;
      pass_cnt    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.psumValid) begin
            proto_err_q <= 1'b1;
          end
          if (bus.start) begin
            state    <= ST_COLLECT;
            wr_idx   <= '0;
            rd_idx   <= '0;
            pass_cnt <= '0;
          end
        end

        ST_COLLECT: begin
          if (bus.start) begin
            proto_err_q <= 1'b1;
          end
          if (bus.psumValid) begin
            if (wr_idx == LastIdx) begin
              wr_idx <= '0;
              if (pass_cnt == LastPass) begin
                state       <= ST_DRAIN;
                out_valid_q <= 1'b1;
                // Row 0 may be the very entry written on this edge when Height is 1.
                out_data_q  <= (LastIdx == '0) ? wr_val : psum_buf[0];
              end else begin
                pass_cnt <= pass_cnt + 1'b1;
              end
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (bus.start || bus.psumValid) begin
            proto_err_q <= 1'b1;
          end
          if (out_valid_q && bus.outReady) begin
            if (rd_idx == LastIdx) begin
              state       <= ST_IDLE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              rd_idx     <= rd_nxt;
              out_data_q <= psum_buf[rd_nxt];
            end
          end
        end

        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.outValid = out_valid_q;
  assign bus.outData  = out_data_q;
  assign bus.busy     = (state == ST_COLLECT) || (state == ST_DRAIN);
  assign bus.done     = done_q;
  assign bus.protoErr = proto_err_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_psum_collector.sv
// Randomized scoreboard bench for psum_collector: a reference model of tile
// accumulation feeds an expected queue that a negedge monitor drains.
module tb_psum_collector;
  import mm_pkg::*;

  localparam int H = 4;
  localparam int W = 16;
  localparam int P = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_collector_if #(.PsumWidth(W)) bus ();
  psum_collector_if #(.PsumWidth(W)) bus1 ();
  state_t dbg_state;
  state_t dbg_state1;

  psum_collector #(.Height(H), .PsumWidth(W), .Passes(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  psum_collector #(.Height(H), .PsumWidth(W), .Passes(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .dbg_state (dbg_state1)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rows [H];
  logic [W-1:0] tile_ps [P][H];
  logic exp_err = 1'b0;
  int tile_accepts = 0;
  int tiles_done = 0;
  logic exp_done = 1'b0;
  logic hold_valid = 1'b0;
  logic [W-1:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] clamp(input longint v);
    longint mx = (longint'(1) <<< (W - 1)) - 1;
    longint mn = -(longint'(1) <<< (W - 1));
    if (v > mx) return W'(mx);
    if (v < mn) return W'(mn);
    return W'(v);
  endfunction

  // Each pass adds into the running result with clamping after every addition.
  task automatic build_expected();
    for (int r = 0; r < H; r++) begin
      longint acc = longint'($signed(tile_ps[0][r]));
      for (int p = 1; p < P; p++) begin
        acc = longint'($signed(clamp(acc + longint'($signed(tile_ps[p][r])))));
      end
      exp_rows[r] = W'(acc);
    end
  endtask

  function automatic logic [W-1:0] rand_psum();
    case ($urandom_range(0, 3))
      0:       return W'(16'h7F00 + $urandom_range(0, 255));
      1:       return W'(16'h8000 + $urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      tile_accepts = 0;
      exp_done     = 1'b0;
      hold_valid   = 1'b0;
    end else begin
      if (exp_done || bus.done) begin
        check("done_pulse", 32'(bus.done), 32'(exp_done));
        if (exp_done) check("valid_low_on_done", 32'(bus.outValid), 32'd0);
      end
      if (bus.done) tiles_done++;
      if (hold_valid && bus.outValid) check("hold_stable", 32'(bus.outData), 32'(held));
      exp_done = 1'b0;
      if (bus.outValid && bus.outReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h expected=none at %0t", bus.outData, $time);
        end else begin
          check("out_data", 32'(bus.outData), 32'(exp_q.pop_front()));
        end
        tile_accepts++;
        if (tile_accepts == H) begin
          tile_accepts = 0;
          exp_done     = 1'b1;
        end
      end
      hold_valid = bus.outValid && !bus.outReady;
      held       = bus.outData;
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: random gaps and random outReady; 1: back-to-back, ready high;
  // 2: stall 3 cycles on the second result; 3: start+psumValid injected in DRAIN.
  task automatic run_tile(input int mode);
    int start_done;
    int budget;
    bit stalled;
    build_expected();
    bus.outReady = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int p = 0; p < P; p++) begin
      for (int r = 0; r < H; r++) begin
        if (mode == 0) begin
          bus.psumValid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
        bus.psumValid = 1'b1;
        bus.psumIn    = tile_ps[p][r];
        if (p == P - 1 && r == H - 1) begin
          check("no_early_valid", 32'(bus.outValid), 32'd0);
          for (int i = 0; i < H; i++) exp_q.push_back(exp_rows[i]);
        end
        tick();
      end
    end
    bus.psumValid = 1'b0;
    check("first_valid_latency", 32'(bus.outValid), 32'd1);
    start_done = tiles_done;
    budget = 0;
    stalled = 1'b0;
    while (tiles_done == start_done && budget < 200) begin
      case (mode)
        0: bus.outReady = ($urandom_range(0, 3) != 0);
        2: begin
          if (!stalled && bus.outValid && tile_accepts == 1) begin
            bus.outReady = 1'b0;
            repeat (3) begin
              tick();
              check("stall_data", 32'(bus.outData), 32'(exp_rows[1]));
            end
            stalled = 1'b1;
          end
          bus.outReady = 1'b1;
        end
        3: begin
          bus.outReady  = 1'b1;
          bus.start     = (budget == 0);
          bus.psumValid = (budget == 0);
          bus.psumIn    = W'($urandom);
          if (budget == 0) exp_err = 1'b1;
        end
        default: bus.outReady = 1'b1;
      endcase
      tick();
      budget++;
      if (mode == 3 && budget == 1) check("start_ignored", 32'(dbg_state), 32'(ST_DRAIN));
    end
    bus.start     = 1'b0;
    bus.psumValid = 1'b0;
    bus.outReady  = 1'b1;
    check("drain_done", 32'(tiles_done != start_done), 32'd1);
    if (mode == 2) check("stall_happened", 32'(stalled), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("idle_after_tile", 32'(dbg_state), 32'(ST_IDLE));
    check("busy_after_tile", 32'(bus.busy), 32'd0);
    check("proto_err", 32'(bus.protoErr), 32'(exp_err));
  endtask

  task automatic load_seq(input int base0, input int step0, input int base1, input int step1);
    for (int r = 0; r < H; r++) begin
      tile_ps[0][r] = W'(base0 + step0 * r);
      tile_ps[1][r] = W'(base1 + step1 * r);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;  bus.psumValid = 1'b0;  bus.psumIn = '0;  bus.outReady = 1'b1;
    bus1.start = 1'b0; bus1.psumValid = 1'b0; bus1.psumIn = '0; bus1.outReady = 1'b1;
    tick();
    check("rst_outValid", 32'(bus.outValid), 32'd0);
    check("rst_outData", 32'(bus.outData), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_protoErr", 32'(bus.protoErr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    tick();

    // Single-pass instance: 1,2,3,4 streams straight through.
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int r = 0; r < H; r++) begin
      bus1.psumValid = 1'b1;
      bus1.psumIn    = W'(r + 1);
      tick();
    end
    bus1.psumValid = 1'b0;
    for (int r = 0; r < H; r++) begin
      check("p1_valid", 32'(bus1.outValid), 32'd1);
      check("p1_data", 32'(bus1.outData), 32'(r + 1));
      tick();
    end
    check("p1_done", 32'(bus1.done), 32'd1);
    check("p1_valid_on_done", 32'(bus1.outValid), 32'd0);
    tick();
    check("p1_done_one_cycle", 32'(bus1.done), 32'd0);
    check("p1_protoErr", 32'(bus1.protoErr), 32'd0);

    // Two passes: 10..40 plus 1..4.
    load_seq(10, 10, 1, 1);
    run_tile(1);

    // Saturation at both rails on rows 0 and 1.
    tile_ps[0][0] = 16'h7FF0; tile_ps[1][0] = 16'h0020;
    tile_ps[0][1] = 16'h8000; tile_ps[1][1] = 16'hFFFF;
    tile_ps[0][2] = rand_psum(); tile_ps[1][2] = rand_psum();
    tile_ps[0][3] = rand_psum(); tile_ps[1][3] = rand_psum();
    run_tile(1);

    // Backpressure on the second result (22).
    load_seq(10, 10, 1, 1);
    run_tile(2);

    // Protocol errors: psum in IDLE, then start/psum during DRAIN.
    bus.psumValid = 1'b1;
    bus.psumIn    = 16'h1234;
    tick();
    bus.psumValid = 1'b0;
    exp_err = 1'b1;
    check("err_idle_psum", 32'(bus.protoErr), 32'd1);
    check("err_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    for (int p = 0; p < P; p++) for (int r = 0; r < H; r++) tile_ps[p][r] = rand_psum();
    run_tile(3);

    // Randomized tiles with random gaps and random backpressure.
    for (int t = 0; t < 8; t++) begin
      for (int p = 0; p < P; p++) for (int r = 0; r < H; r++) tile_ps[p][r] = rand_psum();
      run_tile(0);
    end

    // Reset in the middle of pass 0 aborts the tile.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      bus.psumValid = 1'b1;
      bus.psumIn    = W'(100 + r);
      tick();
    end
    bus.psumValid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_outValid", 32'(bus.outValid), 32'd0);
    check("abort_outData", 32'(bus.outData), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_protoErr", 32'(bus.protoErr), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    load_seq(5, 1, 0, 0);
    run_tile(1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter Height, default 4: number of result rows per output tile, one psum per row per pass.
REQ-002 Parameter PsumWidth, default 16: two's-complement width of partial sums and results.
REQ-003 Parameter Passes, default 2: partial-sum passes accumulated per result (K-dimension tiling).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle arm pulse for a new tile.
REQ-007 psumValid  input  1  psumIn carries a valid partial sum this cycle.
REQ-008 psumIn  input  PsumWidth  partial sum from the array, rows in order 0..Height-1.
REQ-009 outValid  output  1  outData holds a valid result.
REQ-010 outData  output  PsumWidth  accumulated result.
REQ-011 outReady  input  1  downstream accepts outData.
REQ-012 busy  output  1  high in COLLECT or DRAIN.
REQ-013 done  output  1  one-cycle pulse on the final accepted result.
REQ-014 protoErr  output  1  sticky protocol-error flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, COLLECT, DRAIN.
REQ-016 IDLE->COLLECT on start; wrIdx, passCnt and rdIdx SHALL clear to 0 on that edge.
REQ-017 In COLLECT, each psumValid SHALL write buf[wrIdx] = psumIn if passCnt==0, else the sum of buf[wrIdx] and psumIn, saturated to the signed PsumWidth range.
REQ-018 wrIdx SHALL increment per accepted psum and wrap Height-1 -> 0; on each wrap, passCnt SHALL increment.
REQ-019 Acceptance of psum (wrIdx==Height-1, passCnt==Passes-1) SHALL move the FSM to DRAIN on the same edge.
REQ-020 In DRAIN, outValid=1 and outData=buf[rdIdx], both registered; rdIdx SHALL advance only when outValid&&outReady.
REQ-021 outData SHALL hold stable while outValid=1 and outReady=0.
REQ-022 On acceptance with rdIdx==Height-1, the FSM SHALL return to IDLE and done SHALL pulse on the following cycle; outValid SHALL be 0 in that cycle.
REQ-023 First outValid SHALL assert exactly one cycle after the last psum is accepted.
REQ-024 start while busy SHALL be ignored and SHALL set protoErr.
REQ-025 psumValid in IDLE or DRAIN SHALL be ignored (buffer unchanged) and SHALL set protoErr.
REQ-026 protoErr SHALL clear only on rst.
REQ-027 Saturation: the result SHALL clamp to 2^(PsumWidth-1)-1 on positive overflow and to -2^(PsumWidth-1) on negative overflow.

Reset
REQ-028 On rst, asynchronously: FSM=IDLE; wrIdx, passCnt, rdIdx=0; outValid=0, outData=0, busy=0, done=0, protoErr=0.
REQ-029 Buffer contents SHALL be don't-care after reset; there is no readback before a full COLLECT.
REQ-030 rst mid-COLLECT or mid-DRAIN SHALL abort the tile with no done pulse.

Structure
REQ-031 FSM state encoding and the saturating-add width constants SHALL live in the shared package mm_pkg.
REQ-032 Saturating adder SHALL be one sub-module, sat_add, parameterized by PsumWidth; the buffer SHALL be flops inside psum_collector.

Verification
REQ-033 Height=4, Passes=1: start, psums 1,2,3,4 -> outData 1,2,3,4 with outReady=1, done one cycle after 4th accept.
REQ-034 Passes=2: pass0 10,20,30,40, pass1 1,2,3,4 -> 11,22,33,44.
REQ-035 Saturation: pass0 0x7FF0, pass1 0x0020 for row0 -> 0x7FFF; pass0 0x8000, pass1 0xFFFF -> 0x8000.
REQ-036 Backpressure: outReady low 3 cycles on 2nd result -> outData steady at 22, no result lost or duplicated.
REQ-037 Errors: psumValid in IDLE and start during DRAIN -> protoErr=1, buffer and sequence unchanged.
REQ-038 rst asserted after 2 psums of pass0 -> all outputs 0 immediately; next tile with 5,6,7,8 -> 5,6,7,8.
